stage_if: RTL

//  Instruction-fetch stage: holds the PC, issues one 32-bit fetch at a time to the

---
 rtl/stage_if_if.sv | 38 +++
 rtl/stage_if.sv | 139 +++++++++++++
 2 files changed

// File: rtl/stage_if_if.sv
// rtl/stage_if_if.sv - instruction bus between the fetch stage and instruction memory
//
// Purpose: groups the single-outstanding fetch request/response handshake.
// Signals:
//   imem_req_valid  fetch request valid                (fetch -> memory)
//   imem_req_ready  memory accepts the request         (memory -> fetch)
//   imem_req_addr   64-bit fetch address               (fetch -> memory)
//   imem_resp_valid one response per accepted request  (memory -> fetch)
//   imem_resp_data  32-bit instruction word            (memory -> fetch)
//   imem_resp_fault access fault for this response     (memory -> fetch)
// Modports: master = fetch stage side, slave = memory side.

interface stage_if_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_fault;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  imem_resp_fault
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output imem_resp_fault
    );
endinterface

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction-fetch stage producing if2id packets
//
// Purpose: holds the PC, issues one 32-bit fetch at a time on the instruction
// bus and presents each result (or fetch trap) as an if2id packet.
// Ports:
//   clock        single clock, all state on posedge
//   reset_n      asynchronous active-low reset
//   if_flush     redirect: discard current work, restart at redirect_pc
//   redirect_pc  redirect target, sampled only while if_flush=1
//   if_ready     downstream consumes if_data this cycle
//   imem         instruction bus (master side)
//   if_data      if2id packet, 100 bits:
//                [99] if_valid  [98] if_inst_valid  [97] if_misaligned
//                [96] if_acc_fault  [95:32] pc  [31:0] instr

module stage_if #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          if_flush,
    input  logic [63:0]   redirect_pc,
    input  logic          if_ready,
    stage_if_if.master    imem,
    output logic [99:0]   if_data
);

    localparam int unsigned B_VALID      = 99;
    localparam int unsigned B_INST_VALID = 98;
    localparam int unsigned B_MISALIGNED = 97;
    localparam int unsigned B_ACC_FAULT  = 96;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [63:0] pc;
    logic [63:0] pc_nx;
    logic [99:0] pkt_nx;
    logic        aligned;
    logic        handshake;
    logic        pkt_trap;

    assign aligned  = (pc[1:0] == 2'b00);
    assign pkt_trap = if_data[B_MISALIGNED] | if_data[B_ACC_FAULT];

    // Request is purely a function of state; gating with reset_n keeps the
    // bus quiet while reset is held even though the reset state is REQ.
    assign imem.imem_req_valid = reset_n && (state == S_REQ) && aligned;
    assign imem.imem_req_addr  = pc;
    assign handshake           = imem.imem_req_valid && imem.imem_req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            if_data <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            if_data <= pkt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        pkt_nx   = if_data;

        if (if_flush) begin
            // A flush must remember a request the bus still owes us an answer
            // for, so its late response is discarded rather than captured.
            pc_nx  = redirect_pc;
            pkt_nx = '0;
            if ((state == S_WAIT && !imem.imem_resp_valid) ||
                (state == S_REQ  && handshake) ||
                (state == S_DROP && !imem.imem_resp_valid)) begin
                state_nx = S_DROP;
            end else begin
                state_nx = S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (!aligned) begin
                        pkt_nx               = '0;
                        pkt_nx[B_VALID]      = 1'b1;
                        pkt_nx[B_MISALIGNED] = 1'b1;
                        pkt_nx[95:32]        = pc;
                        state_nx             = S_HOLD;
                    end else if (handshake) begin
                        state_nx = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        pkt_nx               = '0;
                        pkt_nx[B_VALID]      = 1'b1;
                        pkt_nx[B_INST_VALID] = !imem.imem_resp_fault;
                        pkt_nx[B_ACC_FAULT]  = imem.imem_resp_fault;
                        pkt_nx[95:32]        = pc;
                        pkt_nx[31:0]         = imem.imem_resp_data;
                        state_nx             = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        pkt_nx = '0;
                        if (pkt_trap) begin
                            // Trap packet: downstream will redirect us.
                            state_nx = S_HALT;
                        end else begin
                            pc_nx    = pc + 64'd4;
                            state_nx = S_REQ;
                        end
                    end
                end
                S_DROP: begin
                    if (imem.imem_resp_valid) begin
                        state_nx = S_REQ;
                    end
                end
                S_HALT: begin
                    state_nx = S_HALT;
                end
                default: begin
                    state_nx = S_REQ;
                end
            endcase
        end
    end

endmodule
